// File: rtl/pmu_pkg.sv
// Shared definitions for the power-management request generator:
// FSM state encoding and wake-cause codes.
package pmu_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_REQ_SLEEP = 2'd1,
        ST_SLEEP     = 2'd2,
        ST_REQ_WAKE  = 2'd3
    } pmu_state_t;

    localparam logic [1:0] WAKE_NONE  = 2'd0;
    localparam logic [1:0] WAKE_EXT   = 2'd1;
    localparam logic [1:0] WAKE_TIMER = 2'd2;
    localparam logic [1:0] WAKE_DIS   = 2'd3;

    localparam logic [31:0] SLEEP_CYC_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pmu_wake_sync.sv
// Two-flop synchronizer for the external wake line followed by a
// rising-edge detector. The edge output is a single main_clk cycle wide.
module pmu_wake_sync
    import pmu_pkg::*;
(
    input  logic main_clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic sync2_d_reg;

    // Metastability chain plus one delay stage for edge detection.
    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            sync2_d_reg <= 1'b0;
        end else begin
            sync1_reg   <= async_in;
            sync2_reg   <= sync1_reg;
            sync2_d_reg <= sync2_reg;
        end
    end

    assign rise = sync2_reg & ~sync2_d_reg;

endmodule

// File: rtl/pmu_request_gen.sv
// Power-management request generator. Watches core activity and wake
// sources, emits single-cycle sleep/wake request pulses towards the sleep
// controller, retries when its sleep_mode acknowledge is late, and keeps
// debug state (last wake cause, saturating sleep-cycle count).
module pmu_request_gen
    import pmu_pkg::*;
#(
    parameter int IDLE_CNT_W  = 16,
    parameter int WAKE_CNT_W  = 24,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                  main_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [IDLE_CNT_W-1:0] idle_threshold,
    input  logic [WAKE_CNT_W-1:0] wake_interval,
    input  logic                  core_active,
    input  logic                  ext_wake_async,
    input  logic                  sleep_mode,
    output logic                  sleep_request,
    output logic                  wakeup_request,
    output logic [1:0]            pmu_state,
    output logic [1:0]            wake_cause,
    output logic [31:0]           sleep_cycles
);

    localparam int ACK_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    pmu_state_t            state_reg;
    logic [IDLE_CNT_W-1:0] idle_cnt_reg;
    logic [WAKE_CNT_W-1:0] wake_cnt_reg;
    logic [ACK_W-1:0]      ack_cnt_reg;
    logic                  wake_pend_reg;
    logic                  sleep_mode_d_reg;
    logic                  sleep_request_reg;
    logic                  wakeup_request_reg;
    logic [1:0]            wake_cause_reg;
    logic [31:0]           sleep_cycles_reg;

    logic ext_rise;
    logic idle_cycle;
    logic idle_hit;
    logic timer_hit;
    logic sleep_mode_rise;
    logic ext_event;
    logic [IDLE_CNT_W-1:0] thr_m1;

    pmu_wake_sync u_wake_sync (
        .main_clk (main_clk),
        .rst      (rst),
        .async_in (ext_wake_async),
        .rise     (ext_rise)
    );

    // Wake and idle qualifiers derived from registered state and inputs.
    always_comb begin
        thr_m1          = idle_threshold - IDLE_CNT_W'(1);
        idle_cycle      = ~core_active & enable & (idle_threshold != '0);
        // >= keeps the trigger robust if the threshold is lowered mid-count.
        idle_hit        = idle_cycle && (idle_cnt_reg >= thr_m1);
        timer_hit       = (wake_interval != '0) && (wake_cnt_reg == WAKE_CNT_W'(1));
        sleep_mode_rise = sleep_mode & ~sleep_mode_d_reg;
        ext_event       = ext_rise | wake_pend_reg;
    end

    // Request FSM with its counters and registered outputs.
    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_RUN;
            idle_cnt_reg       <= '0;
            wake_cnt_reg       <= '0;
            ack_cnt_reg        <= '0;
            wake_pend_reg      <= 1'b0;
            sleep_mode_d_reg   <= 1'b0;
            sleep_request_reg  <= 1'b0;
            wakeup_request_reg <= 1'b0;
            wake_cause_reg     <= WAKE_NONE;
            sleep_cycles_reg   <= '0;
        end else begin
            sleep_request_reg  <= 1'b0;
            wakeup_request_reg <= 1'b0;
            sleep_mode_d_reg   <= sleep_mode;

            if (((state_reg == ST_SLEEP) || (state_reg == ST_REQ_WAKE)) &&
                (sleep_cycles_reg != SLEEP_CYC_MAX)) begin
                sleep_cycles_reg <= sleep_cycles_reg + 32'd1;
            end

            case (state_reg)
                ST_RUN: begin
                    wake_pend_reg <= 1'b0;
                    // A controller-initiated (or late-acknowledged) sleep wins.
                    if (sleep_mode_rise) begin
                        state_reg    <= ST_SLEEP;
                        wake_cnt_reg <= wake_interval;
                        idle_cnt_reg <= '0;
                    end else if (!idle_cycle) begin
                        idle_cnt_reg <= '0;
                    end else if (idle_hit) begin
                        sleep_request_reg <= 1'b1;
                        state_reg         <= ST_REQ_SLEEP;
                        ack_cnt_reg       <= '0;
                        idle_cnt_reg      <= '0;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + IDLE_CNT_W'(1);
                    end
                end

                ST_REQ_SLEEP: begin
                    if (ext_rise) begin
                        wake_pend_reg <= 1'b1;
                    end
                    if (sleep_mode) begin
                        state_reg    <= ST_SLEEP;
                        wake_cnt_reg <= wake_interval;
                    end else if (core_active) begin
                        state_reg <= ST_RUN;
                    end else if (ack_cnt_reg == ACK_LAST) begin
                        sleep_request_reg <= 1'b1;
                        ack_cnt_reg       <= '0;
                    end else begin
                        ack_cnt_reg <= ack_cnt_reg + ACK_W'(1);
                    end
                end

                ST_SLEEP: begin
                    if (wake_cnt_reg != '0) begin
                        wake_cnt_reg <= wake_cnt_reg - WAKE_CNT_W'(1);
                    end
                    if (ext_event || timer_hit || !enable) begin
                        wakeup_request_reg <= 1'b1;
                        state_reg          <= ST_REQ_WAKE;
                        ack_cnt_reg        <= '0;
                        wake_pend_reg      <= 1'b0;
                        if (ext_event) begin
                            wake_cause_reg <= WAKE_EXT;
                        end else if (timer_hit) begin
                            wake_cause_reg <= WAKE_TIMER;
                        end else begin
                            wake_cause_reg <= WAKE_DIS;
                        end
                    end
                end

                ST_REQ_WAKE: begin
                    if (!sleep_mode) begin
                        state_reg    <= ST_RUN;
                        idle_cnt_reg <= '0;
                    end else if (ack_cnt_reg == ACK_LAST) begin
                        wakeup_request_reg <= 1'b1;
                        ack_cnt_reg        <= '0;
                    end else begin
                        ack_cnt_reg <= ack_cnt_reg + ACK_W'(1);
                    end
                end

                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    assign sleep_request  = sleep_request_reg;
    assign wakeup_request = wakeup_request_reg;
    assign pmu_state      = state_reg;
    assign wake_cause     = wake_cause_reg;
    assign sleep_cycles   = sleep_cycles_reg;

endmodule

// File: tb/tb_pmu_request_gen.sv
// Directed bench for pmu_request_gen. Inputs change 1 ns after a rising
// edge; outputs are sampled there too, so each tick() observes the result
// of exactly one clock edge.
module tb_pmu_request_gen;

    logic        main_clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] idle_threshold = 16'd4;
    logic [23:0] wake_interval = 24'd20;
    logic        core_active = 1'b1;
    logic        ext_wake_async = 1'b0;
    logic        sleep_mode = 1'b0;
    logic        sleep_request;
    logic        wakeup_request;
    logic [1:0]  pmu_state;
    logic [1:0]  wake_cause;
    logic [31:0] sleep_cycles;

    int n_vec = 0;
    int n_err = 0;

    always #5 main_clk = ~main_clk;

    pmu_request_gen #(
        .IDLE_CNT_W  (16),
        .WAKE_CNT_W  (24),
        .ACK_TIMEOUT (8)
    ) dut (
        .main_clk       (main_clk),
        .rst            (rst),
        .enable         (enable),
        .idle_threshold (idle_threshold),
        .wake_interval  (wake_interval),
        .core_active    (core_active),
        .ext_wake_async (ext_wake_async),
        .sleep_mode     (sleep_mode),
        .sleep_request  (sleep_request),
        .wakeup_request (wakeup_request),
        .pmu_state      (pmu_state),
        .wake_cause     (wake_cause),
        .sleep_cycles   (sleep_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    // Ticks until the selected pulse is seen; n = ticks taken, -1 on timeout.
    task automatic wait_pulse(input bit wake, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if ((wake ? wakeup_request : sleep_request) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int cnt_s;
    int cnt_w;

    initial begin
        // Reset state
        tick();
        chk("rst_state", {30'd0, pmu_state}, 32'd0);
        chk("rst_pulses", {30'd0, sleep_request, wakeup_request}, 32'd0);
        chk("rst_cause", {30'd0, wake_cause}, 32'd0);
        chk("rst_sleep_cycles", sleep_cycles, 32'd0);
        rst = 1'b0;
        tick();
        tick();

        // Auto-sleep: threshold 4, request after the 4th idle sample
        core_active = 1'b0;
        tick(); tick(); tick();
        chk("auto_no_early_req", {31'd0, sleep_request}, 32'd0);
        tick();
        chk("auto_sleep_req", {31'd0, sleep_request}, 32'd1);
        chk("auto_state_req_sleep", {30'd0, pmu_state}, 32'd1);
        sleep_mode = 1'b1;
        tick();
        chk("auto_req_single", {31'd0, sleep_request}, 32'd0);
        chk("auto_state_sleep", {30'd0, pmu_state}, 32'd2);

        // Timer wake: interval 20 after entering SLEEP
        for (int i = 0; i < 19; i++) tick();
        chk("timer_no_early", {31'd0, wakeup_request}, 32'd0);
        tick();
        chk("timer_wake_req", {31'd0, wakeup_request}, 32'd1);
        chk("timer_cause", {30'd0, wake_cause}, 32'd2);
        chk("timer_state_req_wake", {30'd0, pmu_state}, 32'd3);
        core_active = 1'b1;
        tick();
        chk("timer_req_single", {31'd0, wakeup_request}, 32'd0);
        sleep_mode = 1'b0;
        tick();
        chk("timer_state_run", {30'd0, pmu_state}, 32'd0);
        chk("timer_sleep_cycles", sleep_cycles, 32'd22);

        // External edge coinciding with timer expiry; sleep entered by controller
        tick();
        sleep_mode = 1'b1;
        tick();
        chk("ctrl_sleep_entry", {30'd0, pmu_state}, 32'd2);
        for (int i = 0; i < 17; i++) tick();
        ext_wake_async = 1'b1;
        tick(); tick();
        chk("ext_no_early", {31'd0, wakeup_request}, 32'd0);
        tick();
        chk("ext_wake_req", {31'd0, wakeup_request}, 32'd1);
        chk("ext_beats_timer", {30'd0, wake_cause}, 32'd1);
        tick();
        chk("ext_req_single", {31'd0, wakeup_request}, 32'd0);
        sleep_mode = 1'b0;
        tick();
        chk("ext_state_run", {30'd0, pmu_state}, 32'd0);
        chk("ext_sleep_cycles_accum", sleep_cycles, 32'd44);
        ext_wake_async = 1'b0;
        tick(); tick(); tick();

        // Missing acknowledge: retry after 8 cycles, then abort on activity
        core_active = 1'b0;
        wait_pulse(1'b0, 10, n);
        chk("noack_first_req_latency", n, 32'd4);
        for (int i = 0; i < 7; i++) tick();
        chk("noack_no_early_retry", {31'd0, sleep_request}, 32'd0);
        tick();
        chk("noack_retry", {31'd0, sleep_request}, 32'd1);
        tick(); tick(); tick();
        core_active = 1'b1;
        tick();
        chk("noack_abort_run", {30'd0, pmu_state}, 32'd0);
        cnt_s = 0;
        cnt_w = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sleep_request === 1'b1) cnt_s++;
            if (wakeup_request === 1'b1) cnt_w++;
        end
        chk("noack_no_more_pulses", cnt_s + cnt_w, 32'd0);

        // Boundary: threshold 0 disables auto-sleep
        idle_threshold = 16'd0;
        core_active = 1'b0;
        cnt_s = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sleep_request === 1'b1) cnt_s++;
        end
        chk("thr0_no_req", cnt_s, 32'd0);

        // Boundary: threshold 1 requests after a single idle sample
        core_active = 1'b1;
        idle_threshold = 16'd1;
        tick();
        core_active = 1'b0;
        tick();
        chk("thr1_req", {31'd0, sleep_request}, 32'd1);
        core_active = 1'b1;
        tick();
        chk("thr1_abort_run", {30'd0, pmu_state}, 32'd0);
        idle_threshold = 16'd4;

        // Forced wake by disable, then wake retry while ack is missing
        sleep_mode = 1'b1;
        tick();
        chk("dis_sleep_entry", {30'd0, pmu_state}, 32'd2);
        tick(); tick();
        enable = 1'b0;
        tick();
        chk("dis_wake_req", {31'd0, wakeup_request}, 32'd1);
        chk("dis_cause", {30'd0, wake_cause}, 32'd3);
        for (int i = 0; i < 7; i++) tick();
        chk("wake_no_early_retry", {31'd0, wakeup_request}, 32'd0);
        tick();
        chk("wake_retry", {31'd0, wakeup_request}, 32'd1);
        chk("wake_retry_state", {30'd0, pmu_state}, 32'd3);

        // Reset in REQ_WAKE with a pulse in flight
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_state", {30'd0, pmu_state}, 32'd0);
        chk("midrst_pulses", {30'd0, sleep_request, wakeup_request}, 32'd0);
        chk("midrst_cause", {30'd0, wake_cause}, 32'd0);
        chk("midrst_sleep_cycles", sleep_cycles, 32'd0);
        tick();
        rst = 1'b0;
        enable = 1'b1;
        sleep_mode = 1'b0;
        tick();
        chk("postrst_state", {30'd0, pmu_state}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
